// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: resolver select codes
// and the default register-index type.
package hazard_pkg;

  localparam int NREG_DEF = 32;
  localparam int RW_DEF   = $clog2(NREG_DEF);

  typedef logic [RW_DEF-1:0] reg_idx_t;

  // Per-source resolution outcome, also useful as a debug tap
  localparam logic [1:0] FWD_SEL_NONE  = 2'd0;
  localparam logic [1:0] FWD_SEL_STAGE = 2'd1;
  localparam logic [1:0] FWD_SEL_LL    = 2'd2;
  localparam logic [1:0] FWD_SEL_STALL = 2'd3;

  function automatic logic sel_is_hit(input logic [1:0] sel);
    return (sel == FWD_SEL_STAGE) || (sel == FWD_SEL_LL);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue/forward/completion bundle between decode and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 3
);
  localparam int RW = $clog2(NREG);

  logic                 iss_valid;
  logic                 iss_ready;
  logic                 iss_use_rs1;
  logic                 iss_use_rs2;
  logic [RW-1:0]        iss_rs1;
  logic [RW-1:0]        iss_rs2;
  logic                 iss_wen;
  logic [RW-1:0]        iss_rd;
  logic                 iss_long;
  logic                 flush;
  logic [NFWD-1:0]      fwd_wen;
  logic [NFWD*RW-1:0]   fwd_rd;
  logic [NFWD-1:0]      fwd_rdy;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 ll_done;
  logic [RW-1:0]        ll_rd;
  logic [XLEN-1:0]      ll_data;
  logic                 fwd_rs1_hit;
  logic                 fwd_rs2_hit;
  logic [XLEN-1:0]      fwd_rs1_data;
  logic [XLEN-1:0]      fwd_rs2_data;
  logic                 stall;

  modport master (
    output iss_valid, iss_use_rs1, iss_use_rs2, iss_rs1, iss_rs2, iss_wen, iss_rd,
           iss_long, flush, fwd_wen, fwd_rd, fwd_rdy, fwd_data, ll_done, ll_rd, ll_data,
    input  iss_ready, fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data, stall
  );

  modport slave (
    input  iss_valid, iss_use_rs1, iss_use_rs2, iss_rs1, iss_rs2, iss_wen, iss_rd,
           iss_long, flush, fwd_wen, fwd_rd, fwd_rdy, fwd_data, ll_done, ll_rd, ll_data,
    output iss_ready, fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data, stall
  );

endinterface

// File: rtl/hazard_scoreboard_chk.sv
// Protocol checker: a long-latency completion must target a register that is busy.
module hazard_scoreboard_chk #(
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input logic            clk,
  input logic            rst_n,
  input logic            ll_done,
  input logic [RW-1:0]   ll_rd,
  input logic [NREG-1:0] busy
);

  ll_done_targets_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    (ll_done && (ll_rd != {RW{1'b0}})) |-> busy[ll_rd]
  ) else $error("ll_done for a register that is not busy");

endmodule

// File: rtl/hazard_scoreboard_fwd_select.sv
// Per-source priority resolver: youngest in-order stage, then the long-latency
// completion bypass, then the scoreboard busy bit.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 3,
  parameter int RW   = $clog2(NREG)
) (
  input  logic                 use_src,
  input  logic [RW-1:0]        src,
  input  logic [NFWD-1:0]      fwd_wen,
  input  logic [NFWD*RW-1:0]   fwd_rd,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 ll_done,
  input  logic [RW-1:0]        ll_rd,
  input  logic [XLEN-1:0]      ll_data,
  input  logic [NREG-1:0]      busy,
  output logic [1:0]           sel,
  output logic [XLEN-1:0]      data
);

  logic            st_match_s;
  logic            st_rdy_s;
  logic [XLEN-1:0] st_data_s;

  // Scan oldest to youngest so the youngest matching stage is left standing
  always_comb begin
    st_match_s = 1'b0;
    st_rdy_s   = 1'b0;
    st_data_s  = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_wen[i] && (fwd_rd[i*RW +: RW] == src)) begin
        st_match_s = 1'b1;
        st_rdy_s   = fwd_rdy[i];
        st_data_s  = fwd_data[i*XLEN +: XLEN];
      end else begin
        st_match_s = st_match_s;
      end
    end
  end

  // Resolution priority; x0 never resolves to anything
  always_comb begin
    sel = FWD_SEL_NONE;
    if (!use_src || (src == {RW{1'b0}})) begin
      sel = FWD_SEL_NONE;
    end else if (st_match_s) begin
      sel = st_rdy_s ? FWD_SEL_STAGE : FWD_SEL_STALL;
    end else if (ll_done && (ll_rd == src)) begin
      sel = FWD_SEL_LL;
    end else if (busy[src]) begin
      sel = FWD_SEL_STALL;
    end else begin
      sel = FWD_SEL_NONE;
    end
  end

  // Data mux driven by the resolved select
  always_comb begin
    case (sel)
      FWD_SEL_STAGE: data = st_data_s;
      FWD_SEL_LL:    data = ll_data;
      default:       data = '0;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side RAW/WAW hazard detection with forwarding and a long-latency
// register scoreboard plus a stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_scoreboard_if.slave    bus,
  output logic [NREG-1:0]       busy,
  output logic [XLEN-1:0]       stall_cnt
);

  localparam int RW = $clog2(NREG);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [XLEN-1:0] stall_cnt_r;
  logic [1:0]      sel1_s;
  logic [1:0]      sel2_s;
  logic            waw_s;
  logic            ready_s;
  logic            fire_s;

  fwd_select #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .RW(RW)) u_rs1 (
    .use_src(bus.iss_use_rs1), .src(bus.iss_rs1),
    .fwd_wen(bus.fwd_wen), .fwd_rd(bus.fwd_rd), .fwd_rdy(bus.fwd_rdy), .fwd_data(bus.fwd_data),
    .ll_done(bus.ll_done), .ll_rd(bus.ll_rd), .ll_data(bus.ll_data),
    .busy(busy_r), .sel(sel1_s), .data(bus.fwd_rs1_data)
  );

  fwd_select #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .RW(RW)) u_rs2 (
    .use_src(bus.iss_use_rs2), .src(bus.iss_rs2),
    .fwd_wen(bus.fwd_wen), .fwd_rd(bus.fwd_rd), .fwd_rdy(bus.fwd_rdy), .fwd_data(bus.fwd_data),
    .ll_done(bus.ll_done), .ll_rd(bus.ll_rd), .ll_data(bus.ll_data),
    .busy(busy_r), .sel(sel2_s), .data(bus.fwd_rs2_data)
  );

  // WAW: keep at most one outstanding producer per register across both paths
  always_comb begin
    waw_s = bus.iss_wen && (bus.iss_rd != {RW{1'b0}}) && busy_r[bus.iss_rd]
            && !(bus.ll_done && (bus.ll_rd == bus.iss_rd));
    for (int i = 0; i < NFWD; i++) begin
      if (bus.iss_long && bus.iss_wen && (bus.iss_rd != {RW{1'b0}}) && bus.fwd_wen[i]
          && (bus.fwd_rd[i*RW +: RW] == bus.iss_rd)) begin
        waw_s = 1'b1;
      end else begin
        waw_s = waw_s;
      end
    end
  end

  assign ready_s = (sel1_s != FWD_SEL_STALL) && (sel2_s != FWD_SEL_STALL) && !waw_s && !bus.flush;
  assign fire_s  = bus.iss_valid && ready_s;

  assign bus.iss_ready   = ready_s;
  assign bus.stall       = bus.iss_valid && !ready_s;
  assign bus.fwd_rs1_hit = sel_is_hit(sel1_s);
  assign bus.fwd_rs2_hit = sel_is_hit(sel2_s);

  // Next busy vector: completion clears first so a same-cycle re-issue wins
  always_comb begin
    busy_nxt_s = busy_r;
    if (bus.ll_done) begin
      busy_nxt_s[bus.ll_rd] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (fire_s && bus.iss_long && bus.iss_wen && (bus.iss_rd != {RW{1'b0}})) begin
      busy_nxt_s[bus.iss_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // Scoreboard and stall counter state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r      <= '0;
      stall_cnt_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      if (bus.iss_valid && !ready_s && !bus.flush) begin
        stall_cnt_r <= stall_cnt_r + {{(XLEN-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy      = busy_r;
  assign stall_cnt = stall_cnt_r;

  hazard_scoreboard_chk #(.NREG(NREG), .RW(RW)) u_chk (
    .clk(clk), .rst_n(rst_n), .ll_done(bus.ll_done), .ll_rd(bus.ll_rd), .busy(busy_r)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then random traffic,
// checked against a rule-level reference model.
module tb_hazard_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NFWD = 3;
  localparam int RW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) hif ();
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] stall_cnt;

  hazard_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(hif.slave), .busy(busy), .stall_cnt(stall_cnt)
  );

  // stimulus fields
  bit v, u1, u2, wen, lng, fl, lld;
  int rs1, rs2, rd, llrd;
  logic [XLEN-1:0] lldata;
  bit st_wen[NFWD];
  bit st_rdy[NFWD];
  int st_rd[NFWD];
  logic [XLEN-1:0] st_data[NFWD];

  // reference model state
  bit pend[NREG];
  logic [XLEN-1:0] cnt_m;

  typedef struct {
    bit ready; bit stall;
    bit h1; logic [XLEN-1:0] d1;
    bit h2; logic [XLEN-1:0] d2;
    logic [NREG-1:0] busy; logic [XLEN-1:0] cnt;
  } exp_t;
  typedef struct { bit hit; bit stall; logic [XLEN-1:0] data; } res_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic res_t resolve(input bit use_b, input int src);
    res_t r;
    r = '{hit: 1'b0, stall: 1'b0, data: '0};
    if (!use_b || src == 0) return r;
    for (int i = 0; i < NFWD; i++) begin
      if (st_wen[i] && st_rd[i] == src) begin
        if (st_rdy[i]) begin r.hit = 1'b1; r.data = st_data[i]; end
        else r.stall = 1'b1;
        return r;
      end
    end
    if (lld && llrd == src) begin r.hit = 1'b1; r.data = lldata; return r; end
    if (pend[src]) r.stall = 1'b1;
    return r;
  endfunction

  task automatic idle();
    v = 0; u1 = 0; u2 = 0; wen = 0; lng = 0; fl = 0; lld = 0;
    rs1 = 0; rs2 = 0; rd = 0; llrd = 0; lldata = '0;
    for (int i = 0; i < NFWD; i++) begin
      st_wen[i] = 0; st_rdy[i] = 0; st_rd[i] = 0; st_data[i] = '0;
    end
  endtask

  task automatic step();
    exp_t e;
    res_t r1, r2;
    bit waw;
    hif.iss_valid = v; hif.iss_use_rs1 = u1; hif.iss_use_rs2 = u2;
    hif.iss_rs1 = RW'(rs1); hif.iss_rs2 = RW'(rs2);
    hif.iss_wen = wen; hif.iss_rd = RW'(rd); hif.iss_long = lng; hif.flush = fl;
    hif.ll_done = lld; hif.ll_rd = RW'(llrd); hif.ll_data = lldata;
    for (int i = 0; i < NFWD; i++) begin
      hif.fwd_wen[i] = st_wen[i];
      hif.fwd_rdy[i] = st_rdy[i];
      hif.fwd_rd[i*RW +: RW] = RW'(st_rd[i]);
      hif.fwd_data[i*XLEN +: XLEN] = st_data[i];
    end
    r1 = resolve(u1, rs1);
    r2 = resolve(u2, rs2);
    waw = wen && rd != 0 && pend[rd] && !(lld && llrd == rd);
    for (int i = 0; i < NFWD; i++)
      if (lng && wen && rd != 0 && st_wen[i] && st_rd[i] == rd) waw = 1'b1;
    e.ready = !r1.stall && !r2.stall && !waw && !fl;
    e.stall = v && !e.ready;
    e.h1 = r1.hit; e.d1 = r1.data; e.h2 = r2.hit; e.d2 = r2.data;
    for (int k = 0; k < NREG; k++) e.busy[k] = pend[k];
    e.cnt = cnt_m;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) pend[k] = 1'b0;
      cnt_m = '0;
    end else begin
      if (v && !e.ready && !fl) cnt_m = cnt_m + 32'd1;
      if (lld) pend[llrd] = 1'b0;
      if (v && e.ready && lng && wen && rd != 0) pend[rd] = 1'b1;
    end
    #1;
  endtask

  // monitor: compare the combinational response half a cycle after drive
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("iss_ready", 64'(hif.iss_ready), 64'(e.ready));
      chk("stall", 64'(hif.stall), 64'(e.stall));
      chk("rs1_hit", 64'(hif.fwd_rs1_hit), 64'(e.h1));
      chk("rs1_data", 64'(hif.fwd_rs1_data), 64'(e.d1));
      chk("rs2_hit", 64'(hif.fwd_rs2_hit), 64'(e.h2));
      chk("rs2_data", 64'(hif.fwd_rs2_data), 64'(e.d2));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
    end
  end

  initial begin
    int busy_list[$];
    int waited;
    cnt_m = '0;
    for (int k = 0; k < NREG; k++) pend[k] = 1'b0;
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    step(); step();
    rst_n = 1'b1;

    // nothing active, read x5
    v = 1; u1 = 1; rs1 = 5; step();
    // youngest non-ready stage wins over older ready stage
    st_wen[0] = 1; st_rd[0] = 5; st_rdy[0] = 0;
    st_wen[2] = 1; st_rd[2] = 5; st_rdy[2] = 1; st_data[2] = 32'h11;
    step();
    st_rdy[0] = 1; st_data[0] = 32'h22; step();

    // long op to x7, dependent read stalls until completion bypass
    idle(); v = 1; wen = 1; lng = 1; rd = 7; step();
    idle(); v = 1; u1 = 1; rs1 = 7; repeat (3) step();
    lld = 1; llrd = 7; lldata = 32'hABCD; step();
    idle(); step();

    // completion and new long op to the same register in one cycle
    idle(); v = 1; wen = 1; lng = 1; rd = 7; step();
    idle(); v = 1; wen = 1; lng = 1; rd = 7; lld = 1; llrd = 7; lldata = 32'h5; step();
    idle(); step();
    idle(); lld = 1; llrd = 7; step();

    // WAW against the scoreboard and against an in-order stage
    idle(); v = 1; wen = 1; lng = 1; rd = 9; step();
    idle(); v = 1; wen = 1; rd = 9; step();
    idle(); lld = 1; llrd = 9; step();
    idle(); v = 1; wen = 1; lng = 1; rd = 4; st_wen[1] = 1; st_rd[1] = 4; st_rdy[1] = 1; step();

    // stall counter: ten stalled cycles, two of them flushed
    idle(); rst_n = 1'b0; step(); rst_n = 1'b1;
    v = 1; u1 = 1; rs1 = 3; st_wen[0] = 1; st_rd[0] = 3;
    for (int k = 0; k < 10; k++) begin
      fl = (k == 3 || k == 7);
      step();
    end
    chk("stall_cnt_after_10", 64'(stall_cnt), 64'd8);
    idle(); v = 1; u1 = 1; rs1 = 0; st_wen[0] = 1; st_rd[0] = 0; step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      v = ($urandom_range(3, 0) != 0);
      u1 = $urandom_range(1, 0); u2 = $urandom_range(1, 0);
      rs1 = $urandom_range(7, 0); rs2 = $urandom_range(7, 0);
      wen = $urandom_range(1, 0); rd = $urandom_range(7, 0);
      lng = ($urandom_range(3, 0) == 0);
      fl = ($urandom_range(7, 0) == 0);
      for (int i = 0; i < NFWD; i++) begin
        st_wen[i] = $urandom_range(1, 0);
        st_rd[i] = $urandom_range(7, 0);
        st_rdy[i] = ($urandom_range(3, 0) != 0);
        st_data[i] = $urandom;
      end
      busy_list.delete();
      for (int k = 1; k < NREG; k++) if (pend[k]) busy_list.push_back(k);
      if (busy_list.size() > 0 && $urandom_range(2, 0) == 0) begin
        lld = 1;
        llrd = busy_list[$urandom_range(busy_list.size() - 1, 0)];
        lldata = $urandom;
      end
      step();
    end

    idle(); step();
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
